// File: rtl/sar_pkg.sv
// Shared types and helpers for the SAR ADC controller: FSM states,
// averaging constants and the trial-code function (averaging enabled by SAR_AVG_EN).
package sar_pkg;

   typedef enum logic [1:0] {IDLE, SAMPLE, SETTLE, DECIDE} state_t;

   localparam int AVG_COUNT = 4;
   localparam int AVG_SHIFT = 2;
   localparam int MAX_WIDTH = 16;

   // Keep committed bits above idx, force bit idx high, clear everything below.
   function automatic logic [MAX_WIDTH-1:0] trial_code(input logic [MAX_WIDTH-1:0] committed,
                                                       input logic [3:0]           idx);
      logic [MAX_WIDTH-1:0] above;
      above = {MAX_WIDTH{1'b1}} << idx;
      above = above << 1;
      return (committed & above) | (MAX_WIDTH'(1) << idx);
   endfunction

endpackage

// File: rtl/sar_timer.sv
// Loadable down-counter that paces the sample and settle phases.
// tick_done is high while the count sits at zero.
module sar_timer #(
   parameter int CW = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   output logic          tick_done
);

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - CW'(1);
      end
   end

   assign tick_done = (count == '0);

endmodule

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation controller: drives track/hold and DAC trial codes,
// reads the op-amp comparator MSB first. Define SAR_AVG_EN for 4x averaging.
module sar_adc_ctrl import sar_pkg::*; #(
   parameter int WIDTH         = 8,
   parameter int SAMPLE_CYCLES = 4,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             busy,
   output logic             sample_en,
   output logic [WIDTH-1:0] dac_code,
   input  logic             cmp_in,
   output logic [WIDTH-1:0] result,
   output logic             result_valid,
   input  logic             result_ready,
   output logic             overrun
);

   localparam int MAXC = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);
   localparam logic [CW-1:0] SAMPLE_VAL = CW'(SAMPLE_CYCLES - 1);
   localparam logic [CW-1:0] SETTLE_VAL = CW'(SETTLE_CYCLES - 1);

   state_t           state;
   logic [WIDTH-1:0] code;
   logic [3:0]       bit_idx;
   logic             timer_load;
   logic [CW-1:0]    timer_val;
   logic             tick_done;
   logic [WIDTH-1:0] decided;
   logic [WIDTH-1:0] final_code;
   logic             last_conv;
`ifdef SAR_AVG_EN
   logic [WIDTH+1:0] acc;
   logic [WIDTH+1:0] acc_sum;
   logic [1:0]       avg_cnt;
`endif

   sar_timer #(.CW(CW)) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (timer_load),
      .load_val  (timer_val),
      .tick_done (tick_done)
   );

   always_comb begin
      // dac_code already holds the trial code, so a 1 from the comparator commits it
      decided = cmp_in ? dac_code : code;
`ifdef SAR_AVG_EN
      acc_sum    = acc + (WIDTH+2)'(decided);
      final_code = WIDTH'(acc_sum >> AVG_SHIFT);
      last_conv  = (avg_cnt == 2'(AVG_COUNT - 1));
`else
      final_code = decided;
      last_conv  = 1'b1;
`endif
      timer_load = 1'b0;
      timer_val  = SETTLE_VAL;
      case (state)
         IDLE: begin
            if (start) begin
               timer_load = 1'b1;
               timer_val  = SAMPLE_VAL;
            end
         end
         SAMPLE: timer_load = tick_done;
         SETTLE: begin
            if (tick_done) begin
               timer_load = 1'b1;
               if (bit_idx == 4'd0) timer_val = SAMPLE_VAL;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         code         <= '0;
         bit_idx      <= '0;
         busy         <= 1'b0;
         sample_en    <= 1'b0;
         dac_code     <= '0;
         result       <= '0;
         result_valid <= 1'b0;
         overrun      <= 1'b0;
`ifdef SAR_AVG_EN
         acc          <= '0;
         avg_cnt      <= '0;
`endif
      end else begin
         overrun <= 1'b0;
         if (result_valid && result_ready) result_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state     <= SAMPLE;
                  busy      <= 1'b1;
                  sample_en <= 1'b1;
                  dac_code  <= '0;
                  code      <= '0;
`ifdef SAR_AVG_EN
                  acc       <= '0;
                  avg_cnt   <= '0;
`endif
               end
            end
            SAMPLE: begin
               if (tick_done) begin
                  state     <= SETTLE;
                  sample_en <= 1'b0;
                  bit_idx   <= 4'(WIDTH - 1);
                  dac_code  <= WIDTH'(trial_code('0, 4'(WIDTH - 1)));
               end
            end
            SETTLE: begin
               // the decision happens on the last settle edge; DECIDE is never a resting state
               if (tick_done) begin
                  if (bit_idx != 4'd0) begin
                     code     <= decided;
                     bit_idx  <= bit_idx - 4'd1;
                     dac_code <= WIDTH'(trial_code(16'(decided), bit_idx - 4'd1));
                  end else begin
                     code     <= '0;
                     dac_code <= '0;
                     if (!last_conv) begin
                        state     <= SAMPLE;
                        sample_en <= 1'b1;
`ifdef SAR_AVG_EN
                        acc       <= acc_sum;
                        avg_cnt   <= avg_cnt + 2'd1;
`endif
                     end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (!result_valid || result_ready) begin
                           result       <= final_code;
                           result_valid <= 1'b1;
                        end else begin
                           overrun <= 1'b1;
                        end
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Self-checking bench for sar_adc_ctrl with an ideal comparator model.
// Define SAR_AVG_EN to exercise the 4x averaging build instead of the default one.
module tb_sar_adc_ctrl;

   localparam int W    = 8;
   localparam int S    = 4;
   localparam int T    = 2;
   localparam int CONV = S + W * T;
   localparam int LAT  = 1 + CONV;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         start = 1'b0;
   logic         result_ready = 1'b0;
   logic [W-1:0] vin = '0;
   logic         cmp_in;
   logic         busy, sample_en, result_valid, overrun;
   logic [W-1:0] dac_code, result;
   int           checks = 0;
   int           passes = 0;

   always #5 clk = ~clk;

   assign cmp_in = (vin >= dac_code);

   sar_adc_ctrl #(.WIDTH(W), .SAMPLE_CYCLES(S), .SETTLE_CYCLES(T)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .busy         (busy),
      .sample_en    (sample_en),
      .dac_code     (dac_code),
      .cmp_in       (cmp_in),
      .result       (result),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .overrun      (overrun)
   );

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // An ideal comparator commits exactly the bits of vin, so the trial for bit i
   // is vin's bits above i with bit i set.
   function automatic logic [W-1:0] exp_trial(input logic [W-1:0] v, input int i);
      logic [W-1:0] low_mask;
      low_mask = W'((1 << (i + 1)) - 1);
      return (v & ~low_mask) | W'(1 << i);
   endfunction

   // Runs one conversion from a start at cycle 0 and checks every cycle through LAT+1.
   task automatic run_conv(input logic [W-1:0] v, input logic rdy, input logic rdy_last,
                           input logic hold, input logic [W-1:0] exp_res, input logic exp_ovr);
      logic [W-1:0] tr [W];
      logic [W-1:0] ed;
      for (int i = 0; i < W; i++) tr[i] = exp_trial(v, W - 1 - i);
      vin          = v;
      result_ready = rdy;
      start        = 1'b1;
      step;
      start = hold;
      for (int c = 1; c < LAT; c++) begin
         ed = (c <= S) ? '0 : tr[(c - S - 1) / T];
         chk($sformatf("cyc%0d_v%02h", c, v), 32'({busy, sample_en, dac_code}),
             32'({1'b1, (c <= S), ed}));
         if (c == LAT - 1) result_ready = rdy_last;
         step;
      end
      chk($sformatf("done_ctl_v%02h", v), 32'({busy, sample_en, dac_code, result_valid, overrun}),
          32'({2'b00, W'(0), 1'b1, exp_ovr}));
      chk($sformatf("done_res_v%02h", v), 32'(result), 32'(exp_res));
      $display("conv vin=%02h result=%02h valid=%0b overrun=%0b", v, result, result_valid, overrun);
      if (!hold) start = 1'b0;
      step;
      chk($sformatf("ovr_pulse_v%02h", v), 32'(overrun), 32'(0));
   endtask

   initial begin
      logic [W-1:0] v;
      #3 rst_n = 1'b0;
      step;
      step;
      chk("reset_outs", 32'({busy, sample_en, dac_code, result, result_valid, overrun}), 32'(0));
      rst_n = 1'b1;
      step;

`ifdef SAR_AVG_EN
      begin
         logic [W-1:0] seq [4];
         int           sum;
         int           c;
         logic         busy_gap;
         seq      = '{8'h10, 8'h11, 8'h12, 8'h14};
         sum      = 0;
         busy_gap = 1'b0;
         for (int k = 0; k < 4; k++) sum += int'(seq[k]);
         result_ready = 1'b1;
         vin          = seq[0];
         start        = 1'b1;
         step;
         start = 1'b0;
         c     = 1;
         while (!result_valid && c < 200) begin
            if ((c - 1) % CONV == 0 && (c - 1) / CONV < 4) vin = seq[(c - 1) / CONV];
            if (!busy) busy_gap = 1'b1;
            step;
            c++;
         end
         chk("avg_latency", 32'(c), 32'(4 * CONV + 1));
         chk("avg_result", 32'(result), 32'(sum >> 2));
         chk("avg_busy_held", 32'({busy_gap, busy, overrun}), 32'(0));
         $display("avg result=%02h latency=%0d", result, c);
      end
`else
      // main function and endpoints
      run_conv(8'hA5, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b0);
      chk("consumed", 32'(result_valid), 32'(0));
      run_conv(8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
      run_conv(8'hFF, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b0);
      repeat (6) begin
         v = W'($urandom_range(0, 255));
         run_conv(v, 1'b1, 1'b1, 1'b0, v, 1'b0);
      end

      // back-pressure and overrun
      run_conv(8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0);
      run_conv(8'h77, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b1);
      result_ready = 1'b1;
      step;
      chk("bp_drained", 32'({result_valid, result}), 32'({1'b0, 8'h3C}));
      result_ready = 1'b0;

      // completion coinciding with acceptance replaces without overrun
      run_conv(8'h11, 1'b0, 1'b0, 1'b0, 8'h11, 1'b0);
      run_conv(8'h22, 1'b0, 1'b1, 1'b0, 8'h22, 1'b0);
      chk("coincide_consumed", 32'(result_valid), 32'(0));

      // start held high: one conversion, next acceptance at cycle LAT
      run_conv(8'hC3, 1'b1, 1'b1, 1'b1, 8'hC3, 1'b0);
      chk("restart_at_lat", 32'({busy, sample_en}), 32'(2'b11));
      start = 1'b0;
      for (int n = 0; n < 40 && busy; n++) step;
      chk("restart_done", 32'({busy, result_valid, result}), 32'({2'b01, 8'hC3}));
      step;

      // asynchronous reset mid-conversion
      vin          = 8'h5A;
      result_ready = 1'b1;
      start        = 1'b1;
      step;
      start = 1'b0;
      repeat (9) step;
      rst_n = 1'b0;
      #1;
      chk("async_reset", 32'({busy, sample_en, dac_code, result, result_valid, overrun}), 32'(0));
      step;
      rst_n = 1'b1;
      step;
      run_conv(8'h5A, 1'b1, 1'b1, 1'b0, 8'h5A, 1'b0);
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
